// File: rtl/rst_sequencer.sv
// +----------------------------------------------------------------------------+
// | rst_sequencer: orders core/peripheral reset release after a stable PLL lock |
// | Optional: RST_SEQ_LOCK_MONITOR_EN restarts the sequence on lock loss.       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module rst_sequencer #(
  parameter int unsigned LOCK_STABLE_CYC = 1024,
  parameter int unsigned CORE_DELAY      = 256,
  parameter int unsigned PERIPH_DELAY    = 256,
  parameter int unsigned TIMEOUT_CYC     = 1048576
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       sw_rst,
  output logic       rst_core,
  output logic       rst_periph,
  output logic       rst_done,
  output logic       lock_timeout,
  output logic [2:0] state_dbg
);

  localparam int unsigned CNT_W   = 24;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] CORE_LAST   = CNT_W'(CORE_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIPH_LAST = CNT_W'(PERIPH_DELAY - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYC);

`ifdef RST_SEQ_LOCK_MONITOR_EN
  localparam logic LOCK_MON = 1'b1;
`else
  localparam logic LOCK_MON = 1'b0;
`endif

  if (LOCK_STABLE_CYC < 2 || LOCK_STABLE_CYC > CNT_MAX ||
      CORE_DELAY      < 2 || CORE_DELAY      > CNT_MAX ||
      PERIPH_DELAY    < 2 || PERIPH_DELAY    > CNT_MAX ||
      TIMEOUT_CYC     < 2 || TIMEOUT_CYC     > CNT_MAX) begin : g_param_check
    $error("rst_sequencer: timing parameter outside 2..2^24-1");
  end

  typedef enum logic [2:0] {
    S_HOLD       = 3'd0,
    S_WAIT_LOCK  = 3'd1,
    S_CORE_RUN   = 3'd2,
    S_PERIPH_RUN = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] tcnt, tcnt_nxt, tcnt_inc;
  logic             timeout_nxt;
  logic             lock_meta, lock_s;

  // Synchroniser intentionally unreset so lock state survives a reset pulse.
  always_ff @(posedge clk) begin
    lock_meta <= pll_locked;
    lock_s    <= lock_meta;
  end

  assign tcnt_inc = (tcnt == TIMEOUT_LIM) ? tcnt : tcnt + 1'b1;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    tcnt_nxt    = tcnt;
    timeout_nxt = lock_timeout;
    case (state)
      S_HOLD: begin
        cnt_nxt   = '0;
        tcnt_nxt  = '0;
        state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        tcnt_nxt = tcnt_inc;
        if (tcnt_inc == TIMEOUT_LIM) timeout_nxt = 1'b1;
        if (!lock_s) begin
          cnt_nxt = '0;
        end else if (cnt == LOCK_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_CORE_RUN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_CORE_RUN: begin
        if (LOCK_MON && !lock_s) begin
          cnt_nxt   = '0;
          state_nxt = S_HOLD;
        end else if (cnt == CORE_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_PERIPH_RUN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_PERIPH_RUN: begin
        if (LOCK_MON && !lock_s) begin
          cnt_nxt   = '0;
          state_nxt = S_HOLD;
        end else if (cnt == PERIPH_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_DONE: begin
        if (LOCK_MON && !lock_s) begin
          cnt_nxt   = '0;
          state_nxt = S_HOLD;
        end
      end
      default: begin
        cnt_nxt   = '0;
        tcnt_nxt  = '0;
        state_nxt = S_HOLD;
      end
    endcase
    // Software restart overrides everything but keeps the sticky timeout flag.
    if (sw_rst) begin
      state_nxt   = S_HOLD;
      cnt_nxt     = '0;
      tcnt_nxt    = '0;
      timeout_nxt = lock_timeout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_HOLD;
      cnt          <= '0;
      tcnt         <= '0;
      lock_timeout <= 1'b0;
      rst_core     <= 1'b1;
      rst_periph   <= 1'b1;
      rst_done     <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      tcnt         <= tcnt_nxt;
      lock_timeout <= timeout_nxt;
      rst_core     <= (state_nxt == S_HOLD) || (state_nxt == S_WAIT_LOCK);
      rst_periph   <= (state_nxt == S_HOLD) || (state_nxt == S_WAIT_LOCK) ||
                      (state_nxt == S_CORE_RUN);
      rst_done     <= (state_nxt == S_DONE);
    end
  end

  assign state_dbg = state;

endmodule

`default_nettype wire

// File: tb/tb_rst_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_rst_sequencer: directed bench for rst_sequencer (8/4/4/64 timing).       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rst_sequencer;

  logic       clk = 1'b0;
  logic       reset, pll_locked, sw_rst;
  logic       rst_core, rst_periph, rst_done, lock_timeout;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  rst_sequencer #(
    .LOCK_STABLE_CYC(8),
    .CORE_DELAY     (4),
    .PERIPH_DELAY   (4),
    .TIMEOUT_CYC    (64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pll_locked  (pll_locked),
    .sw_rst      (sw_rst),
    .rst_core    (rst_core),
    .rst_periph  (rst_periph),
    .rst_done    (rst_done),
    .lock_timeout(lock_timeout),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic c, input logic p,
                          input logic d, input logic [2:0] s);
    chk({tag, ".rst_core"},   {7'd0, rst_core},   {7'd0, c});
    chk({tag, ".rst_periph"}, {7'd0, rst_periph}, {7'd0, p});
    chk({tag, ".rst_done"},   {7'd0, rst_done},   {7'd0, d});
    chk({tag, ".state"},      {5'd0, state_dbg},  {5'd0, s});
  endtask

  // Called with the DUT in HOLD and lock_s steady high; next edge is edge 1.
  task automatic expect_sequence(input string tag);
    tick();      chk_outs({tag, "@e1"},  1, 1, 0, 3'd1);
    tick(7);     chk_outs({tag, "@e8"},  1, 1, 0, 3'd1);
    tick();      chk_outs({tag, "@e9"},  0, 1, 0, 3'd2);
    tick(3);     chk_outs({tag, "@e12"}, 0, 1, 0, 3'd2);
    tick();      chk_outs({tag, "@e13"}, 0, 0, 0, 3'd3);
    tick(3);     chk_outs({tag, "@e16"}, 0, 0, 0, 3'd3);
    tick();      chk_outs({tag, "@e17"}, 0, 0, 1, 3'd4);
  endtask

  initial begin
    reset = 1'b1; sw_rst = 1'b0; pll_locked = 1'b1;
    tick(4);
    chk_outs("reset", 1, 1, 0, 3'd0);
    chk("reset.timeout", {7'd0, lock_timeout}, 8'd0);

    // Case 1: steady lock from reset release
    reset = 1'b0;
    expect_sequence("seq1");
    tick(5);
    chk_outs("done_hold", 0, 0, 1, 3'd4);

    // Case 4: software restart pulse in DONE
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    chk_outs("swpulse", 1, 1, 0, 3'd0);
    expect_sequence("seq_sw");

    // Held sw_rst keeps HOLD
    sw_rst = 1'b1;
    tick(3);
    chk_outs("swheld", 1, 1, 0, 3'd0);
    sw_rst = 1'b0;
    expect_sequence("seq_held");

    // Case 5: lock loss in DONE
    pll_locked = 1'b0;
    tick(2);
    chk_outs("lockloss@2", 0, 0, 1, 3'd4);
    tick();
`ifdef RST_SEQ_LOCK_MONITOR_EN
    chk_outs("lockloss@3", 1, 1, 0, 3'd0);
    tick(4);
    chk_outs("lockloss_wait", 1, 1, 0, 3'd1);
`else
    chk_outs("lockloss@3", 0, 0, 1, 3'd4);
    tick(4);
    chk_outs("lockloss_late", 0, 0, 1, 3'd4);
`endif

    // Case 2: one-cycle lock glitch when cnt reaches 5
    reset = 1'b1; pll_locked = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(4);              // edge 4
    pll_locked = 1'b0;
    tick();               // edge 5
    pll_locked = 1'b1;
    tick(4);              // edge 9: unglitched sequence would release here
    chk_outs("glitch@e9", 1, 1, 0, 3'd1);
    tick(5);              // edge 14
    chk_outs("glitch@e14", 1, 1, 0, 3'd1);
    tick();               // edge 15
    chk_outs("glitch@e15", 0, 1, 0, 3'd2);

    // Case 3: lock timeout, then late lock
    reset = 1'b1; pll_locked = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(64);             // edge 64
    chk("to@e64", {7'd0, lock_timeout}, 8'd0);
    tick();               // edge 65
    chk("to@e65", {7'd0, lock_timeout}, 8'd1);
    chk_outs("to@e65", 1, 1, 0, 3'd1);
    tick(10);
    chk("to_sticky", {7'd0, lock_timeout}, 8'd1);
    chk_outs("to_wait", 1, 1, 0, 3'd1);
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    pll_locked = 1'b1;
    chk_outs("to_sw", 1, 1, 0, 3'd0);
    chk("to_sw.timeout", {7'd0, lock_timeout}, 8'd1);
    tick(9);              // lock_s first seen high at edge 3
    chk_outs("late@e9", 1, 1, 0, 3'd1);
    tick();
    chk_outs("late@e10", 0, 1, 0, 3'd2);
    tick(8);
    chk_outs("late@e18", 0, 0, 1, 3'd4);
    chk("late.timeout", {7'd0, lock_timeout}, 8'd1);

    // Case 6: reset with sw_rst during PERIPH_RUN
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(14);
    chk_outs("prerst", 0, 0, 0, 3'd3);
    reset = 1'b1; sw_rst = 1'b1;
    tick();
    chk_outs("midrst", 1, 1, 0, 3'd0);
    chk("midrst.timeout", {7'd0, lock_timeout}, 8'd0);
    reset = 1'b0; sw_rst = 1'b0;
    expect_sequence("seq_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
